// File: rtl/ysyx_041461_pipe_stage_pkg.sv
// Shared types for the ysyx_041461 skid pipeline stage.
`ifndef ysyx_041461_MACRO_V
`define ysyx_041461_MACRO_V
`define ysyx_041461_EMPTY 2'd0
`define ysyx_041461_MAIN  2'd1
`define ysyx_041461_SKID  2'd2
`endif

package ysyx_041461_pipe_stage_pkg;

   // The encoding doubles as the held-entry count, so occupancy is the state itself.
   typedef enum logic [1:0] {
      ST_EMPTY = `ysyx_041461_EMPTY,
      ST_MAIN  = `ysyx_041461_MAIN,
      ST_SKID  = `ysyx_041461_SKID
   } stage_state_t;

endpackage

// File: rtl/ysyx_041461_macro.v
// State encodings for the ysyx_041461 pipeline stage, shared by any file that needs them.
`ifndef ysyx_041461_MACRO_V
`define ysyx_041461_MACRO_V
`define ysyx_041461_EMPTY 2'd0
`define ysyx_041461_MAIN  2'd1
`define ysyx_041461_SKID  2'd2
`endif

// File: rtl/ysyx_041461_pipe_entry.sv
// One payload register with load enable and a parameterised reset value.
module ysyx_041461_pipe_entry #(
   parameter int unsigned          DATA_W    = 64,
   parameter logic [DATA_W-1:0]    RESET_VAL = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [DATA_W-1:0] d,
   output logic [DATA_W-1:0] q
);

   always_ff @(posedge clk) begin
      if (rst) begin
         q <= RESET_VAL;
      end else if (load) begin
         q <= d;
      end
   end

endmodule

// File: rtl/ysyx_041461_pipe_stage.sv
// Two-entry skid pipeline register: registered in_ready, full throughput, order preserved.
// Handshake: a beat moves on a side exactly when its valid and ready are both 1 at a rising edge.
module ysyx_041461_pipe_stage
   import ysyx_041461_pipe_stage_pkg::*;
#(
   parameter int unsigned DATA_W     = 64,
   parameter logic [63:0] RESET_DATA = 64'h0000_0000_8000_0000,
   parameter int unsigned CNT_W      = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  stall_cnt
);

   // Zero-extend then truncate so any DATA_W gets a well-defined reset value.
   localparam logic [DATA_W+63:0] RESET_EXT = {{DATA_W{1'b0}}, RESET_DATA};
   localparam logic [DATA_W-1:0]  MAIN_RST  = RESET_EXT[DATA_W-1:0];

   stage_state_t      state_q, state_d;
   logic              in_ready_q;
   logic              accept, dequeue;
   logic              main_load, skid_load;
   logic [DATA_W-1:0] main_d, main_q, skid_q;
   logic [CNT_W-1:0]  stall_q;

   assign out_valid = (state_q != ST_EMPTY);
   assign in_ready  = in_ready_q;
   assign accept    = in_valid && in_ready_q;
   assign dequeue   = out_valid && out_ready;
   assign out_data  = main_q;
   assign occupancy = state_q;
   assign stall_cnt = stall_q;

   always_comb begin
      state_d   = state_q;
      main_load = 1'b0;
      skid_load = 1'b0;
      main_d    = in_data;
      case (state_q)
         ST_EMPTY: begin
            if (accept) begin
               state_d   = ST_MAIN;
               main_load = 1'b1;
            end
         end
         ST_MAIN: begin
            if (accept && dequeue) begin
               main_load = 1'b1;
            end else if (dequeue) begin
               state_d = ST_EMPTY;
            end else if (accept) begin
               state_d   = ST_SKID;
               skid_load = 1'b1;
            end
         end
         ST_SKID: begin
            if (dequeue) begin
               state_d   = ST_MAIN;
               main_load = 1'b1;
               main_d    = skid_q;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
      // Flush drops everything, including a beat accepted this cycle; registers hold.
      if (flush) begin
         state_d   = ST_EMPTY;
         main_load = 1'b0;
         skid_load = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_EMPTY;
         in_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         in_ready_q <= (state_d != ST_SKID);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_q <= '0;
      end else if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
         stall_q <= stall_q + CNT_W'(1);
      end
   end

   ysyx_041461_pipe_entry #(
      .DATA_W    (DATA_W),
      .RESET_VAL (MAIN_RST)
   ) u_main (
      .clk  (clk),
      .rst  (rst),
      .load (main_load),
      .d    (main_d),
      .q    (main_q)
   );

   ysyx_041461_pipe_entry #(
      .DATA_W    (DATA_W),
      .RESET_VAL ('0)
   ) u_skid (
      .clk  (clk),
      .rst  (rst),
      .load (skid_load),
      .d    (in_data),
      .q    (skid_q)
   );

endmodule

// File: tb/tb_ysyx_041461_pipe_stage.sv
// Randomised and directed bench for the skid pipeline stage, checked against a queue model.
module tb_ysyx_041461_pipe_stage;

   localparam int unsigned DATA_W = 64;
   localparam int unsigned CNT_W  = 4;
   localparam logic [DATA_W-1:0] RST_VAL = 64'h0000_0000_8000_0000;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              flush = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [DATA_W-1:0] in_data = '0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [DATA_W-1:0] out_data;
   logic [1:0]        occupancy;
   logic [CNT_W-1:0]  stall_cnt;

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model: the stage is a FIFO of at most two beats.
   logic [DATA_W-1:0] exp_q[$];
   int                exp_stall = 0;
   bit                fresh_reset = 1'b0;

   ysyx_041461_pipe_stage #(
      .DATA_W     (DATA_W),
      .RESET_DATA (64'h0000_0000_8000_0000),
      .CNT_W      (CNT_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .occupancy (occupancy),
      .stall_cnt (stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor/scoreboard: compare on the falling edge, then advance the model for the coming rising edge.
   always @(negedge clk) begin
      int  sz;
      bit  e_valid, e_ready, acc, deq;
      sz      = exp_q.size();
      e_valid = (sz > 0);
      e_ready = (sz < 2);
      if (rst) begin
         exp_q.delete();
         exp_stall   = 0;
         fresh_reset = 1'b1;
      end else begin
         check("occupancy", DATA_W'(occupancy), DATA_W'(sz));
         check("in_ready", DATA_W'(in_ready), DATA_W'(e_ready));
         check("out_valid", DATA_W'(out_valid), DATA_W'(e_valid));
         check("stall_cnt", DATA_W'(stall_cnt), DATA_W'(exp_stall));
         if (e_valid) begin
            check("out_data", out_data, exp_q[0]);
         end else if (fresh_reset) begin
            check("reset_data", out_data, RST_VAL);
         end
         acc = in_valid && e_ready;
         deq = e_valid && out_ready;
         if (e_valid && !out_ready && exp_stall < 15) exp_stall++;
         if (flush) begin
            exp_q.delete();
         end else begin
            if (deq) void'(exp_q.pop_front());
            if (acc) begin
               exp_q.push_back(in_data);
               fresh_reset = 1'b0;
            end
         end
      end
   end

   // Drive one cycle's inputs, starting just after a rising edge.
   task automatic cycle(input bit iv, input logic [DATA_W-1:0] d, input bit ordy, input bit fl);
      in_valid  = iv;
      in_data   = d;
      out_ready = ordy;
      flush     = fl;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cycle(1'b0, '0, 1'b0, 1'b0);
      cycle(1'b0, '0, 1'b0, 1'b0);
      rst = 1'b0;
   endtask

   initial begin
      @(posedge clk);
      #1;
      do_reset();
      cycle(1'b0, '0, 1'b0, 1'b0);

      // Full-rate stream.
      for (int i = 1; i <= 8; i++) cycle(1'b1, DATA_W'(i), 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0);

      // Fill both entries, then drain in order.
      do_reset();
      cycle(1'b1, 64'hA, 1'b0, 1'b0);
      cycle(1'b1, 64'hB, 1'b0, 1'b0);
      cycle(1'b0, '0, 1'b0, 1'b0);
      cycle(1'b0, '0, 1'b1, 1'b0);
      cycle(1'b0, '0, 1'b1, 1'b0);
      cycle(1'b0, '0, 1'b0, 1'b0);

      // Flush while full with an offered beat; it must never appear.
      do_reset();
      cycle(1'b1, 64'hD, 1'b0, 1'b0);
      cycle(1'b1, 64'hE, 1'b0, 1'b0);
      cycle(1'b1, 64'hC, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0);

      // Flush coinciding with a dequeue.
      cycle(1'b1, 64'h11, 1'b0, 1'b0);
      cycle(1'b1, 64'h22, 1'b1, 1'b1);
      cycle(1'b0, '0, 1'b1, 1'b0);

      // Long stall saturates the narrow counter.
      do_reset();
      cycle(1'b1, 64'h5, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) cycle(1'b0, '0, 1'b0, 1'b0);
      cycle(1'b0, '0, 1'b1, 1'b0);

      // Reset in the middle of a stall with both entries held.
      do_reset();
      cycle(1'b1, 64'h77, 1'b0, 1'b0);
      cycle(1'b1, 64'h88, 1'b0, 1'b0);
      do_reset();
      for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, 1'b0);

      // Random traffic with occasional flushes.
      do_reset();
      for (int i = 0; i < 800; i++) begin
         cycle(1'($urandom_range(0, 1)), {$urandom, $urandom},
               ($urandom_range(0, 3) != 0), ($urandom_range(0, 24) == 0));
      end
      for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, 1'b0);

      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
